// File: rtl/round_ctrl.sv
// AES round sequencer: whitening, NR round-transform requests, final round without MixColumns.
// Optional ROUND_CTRL_ZEROIZE_EN: ct_o is gated to the DONE cycle and the state is wiped after it.
module round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] pt_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         rt_start_o,
    output logic [127:0] rt_state_o,
    input  logic [127:0] rt_sr_i,
    input  logic [127:0] rt_mc_i,
    input  logic         rt_done_i,
    output logic [127:0] ct_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] NrLast = 4'(NR);

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        data_d  = data_q;
        unique case (fsm_q)
            StIdle: begin
                if (start_i) begin
                    data_d  = pt_i ^ rk_i;
                    round_d = 4'd1;
                    fsm_d   = StIssue;
                end
            end
            StIssue: fsm_d = StWait;
            StWait: begin
                if (rt_done_i) begin
                    // Last round uses the ShiftRows-only result.
                    if (round_q == NrLast) begin
                        data_d = rt_sr_i ^ rk_i;
                        fsm_d  = StDone;
                    end else begin
                        data_d  = rt_mc_i ^ rk_i;
                        round_d = round_q + 4'd1;
                        fsm_d   = StIssue;
                    end
                end
            end
            StDone: begin
                fsm_d = StIdle;
`ifdef ROUND_CTRL_ZEROIZE_EN
                data_d = '0;
`endif
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= StIdle;
            round_q <= 4'd0;
            data_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        rk_idx_o   = (fsm_q == StIdle) ? 4'd0 : round_q;
        rt_start_o = (fsm_q == StIssue);
        rt_state_o = data_q;
        done_o     = (fsm_q == StDone);
        busy_o     = (fsm_q != StIdle);
`ifdef ROUND_CTRL_ZEROIZE_EN
        ct_o       = (fsm_q == StDone) ? data_q : '0;
`else
        ct_o       = data_q;
`endif
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: AES-128 key schedule and round transform modelled here,
// with FIPS-197 vectors and hand-derived timing expectations.
module tb_round_ctrl;

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] pt_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic         rt_start_o;
    logic [127:0] rt_state_o;
    logic [127:0] rt_sr_i;
    logic [127:0] rt_mc_i;
    logic         rt_done_i;
    logic [127:0] ct_o;
    logic         done_o;
    logic         busy_o;

    logic [127:0] rka [0:15];
    logic [127:0] rkb [0:15];
    logic         key_sel;
    logic         spur;
    int           lat;

    logic [127:0] sr_m = '0;
    logic [127:0] mc_m = '0;
    logic         done_m = 1'b0;
    int           cnt_m = 0;

    int           cyc = 0;
    int           done_cnt = 0;
    int           start_cnt = 0;
    int           mdone_cnt = 0;
    int           acc_cyc = 0;
    int           done_cyc = 0;
    logic [43:0]  seq = '0;

    int           n_chk = 0;
    int           n_pass = 0;

    round_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .pt_i       (pt_i),
        .rk_idx_o   (rk_idx_o),
        .rk_i       (rk_i),
        .rt_start_o (rt_start_o),
        .rt_state_o (rt_state_o),
        .rt_sr_i    (rt_sr_i),
        .rt_mc_i    (rt_mc_i),
        .rt_done_i  (rt_done_i),
        .ct_o       (ct_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as b^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] p;
        sq = b;
        p  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic expand(input logic [127:0] key, input bit which);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) begin
            if (which) rkb[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            else       rka[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        end
    endtask

    assign rk_i      = key_sel ? rkb[rk_idx_o] : rka[rk_idx_o];
    assign rt_done_i = done_m | spur;
    assign rt_sr_i   = spur ? 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0 : sr_m;
    assign rt_mc_i   = spur ? 128'hdead_beef_cafe_f00d_0bad_c0de_1357_9bdf : mc_m;

    // Round transform with programmable latency: rt_start_o cycle to rt_done_i cycle = lat.
    always @(posedge clk) begin
        if (rst) begin
            done_m <= 1'b0;
            cnt_m  <= 0;
        end else begin
            done_m <= 1'b0;
            if (rt_start_o) begin
                sr_m <= sub_shift(rt_state_o);
                mc_m <= mix(sub_shift(rt_state_o));
                if (lat <= 1) done_m <= 1'b1;
                else          cnt_m  <= lat - 1;
            end else if (cnt_m == 1) begin
                done_m <= 1'b1;
                cnt_m  <= 0;
            end else if (cnt_m > 1) begin
                cnt_m <= cnt_m - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (rt_start_o) start_cnt <= start_cnt + 1;
        if (done_m) mdone_cnt <= mdone_cnt + 1;
        if (start_i && !busy_o && !rst) begin
            acc_cyc <= cyc;
            seq     <= {40'h0, rk_idx_o};
        end else if (done_m) begin
            seq <= {seq[39:0], rk_idx_o};
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Start one encryption and return at the negedge of its done_o cycle.
    task automatic enc(input logic [127:0] pt, input logic [127:0] exp_ct, input bit noisy,
                       input string tag);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        pt_i    = pt;
        @(posedge clk); #1;
        start_i = noisy;
        pt_i    = ~pt;
        spur    = noisy;
        @(posedge clk); #1;
        spur    = 1'b0;
        start_i = noisy;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk({tag, "_seen"}, 128'(seen), 128'd1);
        chk({tag, "_ct"}, ct_o, exp_ct);
        if (noisy) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int d0, s0, m0;
        rst     = 1'b1;
        start_i = 1'b0;
        pt_i    = '0;
        spur    = 1'b0;
        key_sel = 1'b0;
        lat     = 1;
        for (int i = 0; i < 16; i++) begin
            rka[i] = '0;
            rkb[i] = '0;
        end
        expand(KeyC1, 1'b0);
        expand(KeyB, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_rt_start", 128'(rt_start_o), 128'd0);
        chk("rst_ct", ct_o, 128'd0);
        chk("rst_rt_state", rt_state_o, 128'd0);
        chk("rst_rk_idx", 128'(rk_idx_o), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 C.1, latency 1
        d0 = done_cnt;
        enc(PtC1, CtC1, 1'b0, "fips");
        repeat (3) @(posedge clk);
        #1;
        chk("fips_done_pulses", 128'(done_cnt - d0), 128'd1);

        // Latency 2: done 31 cycles after accept, 10 issues, keys 0..10
        lat = 2;
        s0  = start_cnt;
        enc(PtC1, CtC1, 1'b0, "lat2");
        repeat (2) @(posedge clk);
        #1;
        chk("lat2_latency", 128'(done_cyc - acc_cyc), 128'd31);
        chk("lat2_rt_starts", 128'(start_cnt - s0), 128'd10);
        chk("lat2_rk_seq", 128'(seq), 128'h0123456789a);

        // Re-pulsed start in ISSUE/WAIT/DONE, spurious rt_done in ISSUE
        d0 = done_cnt;
        enc(PtC1, CtC1, 1'b1, "noisy");
        repeat (40) @(posedge clk);
        #1;
        chk("noisy_done_pulses", 128'(done_cnt - d0), 128'd1);
        chk("noisy_idle", 128'(busy_o), 128'd0);

        // Reset after round 5
        lat = 1;
        d0  = done_cnt;
        m0  = mdone_cnt;
        @(posedge clk); #1;
        start_i = 1'b1;
        pt_i    = PtC1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 200 && (mdone_cnt - m0) < 5; i++) @(negedge clk);
        chk("mid_rounds_reached", 128'((mdone_cnt - m0) >= 5), 128'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 128'(busy_o), 128'd0);
        chk("mid_rst_done", 128'(done_o), 128'd0);
        chk("mid_rst_rt_start", 128'(rt_start_o), 128'd0);
        chk("mid_rst_ct", ct_o, 128'd0);
        chk("mid_rst_rt_state", rt_state_o, 128'd0);
        chk("mid_rst_rk_idx", 128'(rk_idx_o), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_no_done", 128'(done_cnt - d0), 128'd0);
        enc(PtC1, CtC1, 1'b0, "after_rst");

        // Back-to-back: second start in the cycle after done_o, with a different key
        enc(PtC1, CtC1, 1'b0, "b2b_first");
        key_sel = 1'b1;
        enc(PtB, CtB, 1'b0, "b2b_second");
        repeat (5) @(negedge clk);
`ifdef ROUND_CTRL_ZEROIZE_EN
        chk("ct_after_done", ct_o, 128'd0);
`else
        chk("ct_after_done", ct_o, CtB);
`endif
        key_sel = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES rounds (10 = AES-128); legal values 10, 12, 14.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  single-cycle request to encrypt pt_i.
REQ-005 SHALL have port pt_i  input  128  plaintext, sampled on the accepted start_i cycle.
REQ-006 SHALL have port rk_idx_o  output  4  index of the round key being requested.
REQ-007 SHALL have port rk_i  input  128  round key for rk_idx_o, combinationally valid in the same cycle.
REQ-008 SHALL have port rt_start_o  output  1  start pulse to the downstream round-transform stage.
REQ-009 SHALL have port rt_state_o  output  128  state fed to the round-transform stage.
REQ-010 SHALL have port rt_sr_i  input  128  round-transform result after ShiftRows, without MixColumns.
REQ-011 SHALL have port rt_mc_i  input  128  round-transform result after MixColumns.
REQ-012 SHALL have port rt_done_i  input  1  round-transform result valid, single-cycle pulse.
REQ-013 SHALL have port ct_o  output  128  ciphertext.
REQ-014 SHALL have port done_o  output  1  single-cycle pulse, ct_o valid.
REQ-015 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE, WAIT and DONE, plus a 128-bit state register and a 4-bit round counter.
REQ-017 In IDLE, rk_idx_o SHALL be 0; on start_i=1, the FSM SHALL load state <= pt_i XOR rk_i, set round <= 1 and go to ISSUE.
REQ-018 In ISSUE, rt_start_o SHALL be 1 for exactly one cycle with rt_state_o = state, and the FSM SHALL go to WAIT.
REQ-019 In WAIT, rk_idx_o SHALL equal round, and the FSM SHALL hold until rt_done_i=1.
REQ-020 On rt_done_i in WAIT with round < NR, the FSM SHALL load state <= rt_mc_i XOR rk_i, increment round and go to ISSUE.
REQ-021 On rt_done_i in WAIT with round = NR, the FSM SHALL load state <= rt_sr_i XOR rk_i and go to DONE; this final round skips MixColumns.
REQ-022 In DONE, done_o SHALL be 1 for one cycle with ct_o = state, and the FSM SHALL return to IDLE.
REQ-023 rt_state_o SHALL equal the state register at all times; rt_start_o SHALL be 0 outside ISSUE.
REQ-024 start_i SHALL be ignored in ISSUE, WAIT and DONE; there is no queuing.
REQ-025 rt_done_i SHALL be ignored outside WAIT.
REQ-026 For a round-transform latency of L cycles (rt_start_o cycle to rt_done_i cycle), done_o SHALL assert NR*(L+1)+1 cycles after the accepted start_i cycle.
REQ-027 A start_i arriving in the cycle after DONE, while in IDLE, SHALL be accepted, giving back-to-back operation.

Reset
REQ-028 While rst=1, the block SHALL force state=IDLE, round=0, state register=0, rt_start_o=0, done_o=0 and busy_o=0; ct_o and rt_state_o SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done_o pulse; after release, the FSM SHALL restart from IDLE.

Configuration
REQ-030 With the macro ROUND_CTRL_ZEROIZE_EN defined, ct_o SHALL be 0 except in the DONE cycle, and the state register SHALL be cleared to 0 on the DONE-to-IDLE transition.
REQ-031 Without ROUND_CTRL_ZEROIZE_EN, ct_o SHALL equal the state register and SHALL hold the last ciphertext until the next accepted start_i.

Verification
REQ-032 The bench SHALL cover: FIPS-197 pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, real round_tf, NR=10 -> ct_o 69c4e0d86a7b0430d8cdb78070b4c55a with one done_o pulse.
REQ-033 The bench SHALL cover: a stub round_tf with L=2, start_i at cycle 0 -> done_o at cycle 31, and exactly 10 rt_start_o pulses with rk_idx_o sequence 0,1,...,10.
REQ-034 The bench SHALL cover: start_i re-pulsed in ISSUE, WAIT and DONE, plus a spurious rt_done_i in ISSUE -> the result is unchanged from the single-start run, with no extra done_o.
REQ-035 The bench SHALL cover: rst pulsed after round 5 -> all outputs 0 immediately, no done_o, and a subsequent FIPS vector still passes.
REQ-036 The bench SHALL cover: two encryptions back-to-back, second start_i in the cycle after done_o -> both ciphertexts correct.
REQ-037 The bench SHALL cover: ct_o checked 5 cycles after done_o -> 0 with ROUND_CTRL_ZEROIZE_EN defined, and the held ciphertext without it.
